// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a latency-matched pixel request port.
// Sync, blank and frame/line markers are delayed so they leave aligned with pixel data.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 24,
  parameter int PIX_LAT  = 2,
  parameter int CW       = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              req,
  output logic [CW-1:0]     req_x,
  output logic [CW-1:0]     req_y,
  input  logic [DATA_W-1:0] pix_data,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_AS    = H_SYNC + H_BACK;
  localparam int H_AE    = H_AS + H_ACTIVE;
  localparam int V_AS    = V_SYNC + V_BACK;
  localparam int V_AE    = V_AS + V_ACTIVE;

  // One extra bit so region bounds equal to the total still compare correctly.
  localparam logic [CW:0]   H_SYNC_C = (CW+1)'(H_SYNC);
  localparam logic [CW:0]   H_AS_C   = (CW+1)'(H_AS);
  localparam logic [CW:0]   H_AE_C   = (CW+1)'(H_AE);
  localparam logic [CW:0]   V_SYNC_C = (CW+1)'(V_SYNC);
  localparam logic [CW:0]   V_AS_C   = (CW+1)'(V_AS);
  localparam logic [CW:0]   V_AE_C   = (CW+1)'(V_AE);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_OFF    = CW'(H_AS);
  localparam logic [CW-1:0] V_OFF    = CW'(V_AS);

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
           CW, H_TOTAL - 1, V_TOTAL - 1);
  end
  if (PIX_LAT < 0 || PIX_LAT > 15) begin : g_lat_check
    $error("vga_timing_gen: PIX_LAT=%0d outside 0..15", PIX_LAT);
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } tim_t;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW:0]   h_ext;
  logic [CW:0]   v_ext;
  logic          h_act;
  logic          v_act;
  tim_t          raw;
  tim_t          s1_q;
  tim_t          dl_out;
  tim_t          out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign h_act = (h_ext >= H_AS_C) && (h_ext < H_AE_C);
  assign v_act = (v_ext >= V_AS_C) && (v_ext < V_AE_C);

  assign raw = '{hs: (h_ext < H_SYNC_C),
                 vs: (v_ext < V_SYNC_C),
                 de: (h_act && v_act),
                 fs: (h_cnt == '0 && v_cnt == '0),
                 ls: (h_cnt == '0)};

  // req is a fire-and-forget request with no back-pressure: the source must
  // present the pixel for (req_x, req_y) exactly PIX_LAT clocks after req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req   <= 1'b0;
      req_x <= '0;
      req_y <= '0;
      s1_q  <= '0;
    end else if (!en) begin
      req   <= 1'b0;
      req_x <= '0;
      req_y <= '0;
      s1_q  <= '0;
    end else begin
      req   <= raw.de;
      req_x <= raw.de ? (h_cnt - H_OFF) : '0;
      req_y <= raw.de ? (v_cnt - V_OFF) : '0;
      s1_q  <= raw;
    end
  end

  if (PIX_LAT == 0) begin : g_no_delay
    assign dl_out = s1_q;
  end else begin : g_delay
    tim_t dl_q [PIX_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIX_LAT; i++) dl_q[i] <= '0;
      end else if (!en) begin
        for (int i = 0; i < PIX_LAT; i++) dl_q[i] <= '0;
      end else begin
        dl_q[0] <= s1_q;
        for (int i = 1; i < PIX_LAT; i++) dl_q[i] <= dl_q[i-1];
      end
    end

    assign dl_out = dl_q[PIX_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      rgb   <= '0;
    end else if (!en) begin
      out_q <= '0;
      rgb   <= '0;
    end else begin
      out_q <= dl_out;
      rgb   <= dl_out.de ? pix_data : '0;
    end
  end

  // Stored sync terms are "active" flags; polarity is applied only at the pins.
  assign hs          = HS_POL ? out_q.hs : ~out_q.hs;
  assign vs          = VS_POL ? out_q.vs : ~out_q.vs;
  assign de          = out_q.de;
  assign frame_start = out_q.fs;
  assign line_start  = out_q.ls;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five instances (latency 0/1/2/5, both polarities, default 640x480)
// checked every cycle against a position-based model, plus a hand-computed vector table.
module tb_vga_timing_gen;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   n;
  int   vectors;
  int   miscompares;

  logic        req_w [NI];
  logic [10:0] rx_w  [NI];
  logic [10:0] ry_w  [NI];
  logic        hs_w  [NI];
  logic        vs_w  [NI];
  logic        de_w  [NI];
  logic        fs_w  [NI];
  logic        ls_w  [NI];
  logic [23:0] rgb_w [NI];

  always #5 clk = ~clk;

  function automatic logic [23:0] pix_of(logic [10:0] x, logic [10:0] y);
    return {y[7:0], x[7:0], 8'hA5};
  endfunction

  // ---------------------------------------------------------------- instances
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit BIG = (g == 4);
    localparam bit POL = (g == 1);
    localparam int L   = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : (g == 3) ? 5 : 2;

    logic        rq;
    logic [10:0] rx;
    logic [10:0] ry;
    logic [23:0] src;
    logic [23:0] pix;
    logic        h_o;
    logic        v_o;
    logic        d_o;
    logic        f_o;
    logic        l_o;
    logic [23:0] c_o;

    vga_timing_gen #(
      .H_SYNC(BIG ? 96 : 2), .H_BACK(BIG ? 48 : 2), .H_ACTIVE(BIG ? 640 : 4), .H_FRONT(BIG ? 16 : 2),
      .V_SYNC(BIG ? 2 : 1), .V_BACK(BIG ? 33 : 1), .V_ACTIVE(BIG ? 480 : 3), .V_FRONT(BIG ? 10 : 1),
      .HS_POL(POL), .VS_POL(POL), .DATA_W(24), .PIX_LAT(L), .CW(11)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req(rq), .req_x(rx), .req_y(ry), .pix_data(pix),
      .hs(h_o), .vs(v_o), .de(d_o), .rgb(c_o),
      .frame_start(f_o), .line_start(l_o)
    );

    assign src = rq ? pix_of(rx, ry) : 24'hBADBAD;

    if (L == 0) begin : g_l0
      assign pix = src;
    end else begin : g_ln
      logic [23:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= src;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign pix = pipe[L-1];
    end

    assign req_w[g] = rq;
    assign rx_w[g]  = rx;
    assign ry_w[g]  = ry;
    assign hs_w[g]  = h_o;
    assign vs_w[g]  = v_o;
    assign de_w[g]  = d_o;
    assign fs_w[g]  = f_o;
    assign ls_w[g]  = l_o;
    assign rgb_w[g] = c_o;
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf, lat;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic        req;
    logic [10:0] rx;
    logic [10:0] ry;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ls;
    logic [23:0] rgb;
  } exp_t;

  function automatic cfg_t cfg_of(int k);
    cfg_t c;
    if (k == 4) begin
      c.hs = 96; c.hb = 48; c.ha = 640; c.hf = 16;
      c.vs = 2;  c.vb = 33; c.va = 480; c.vf = 10;
      c.lat = 2;
    end else begin
      c.hs = 2; c.hb = 2; c.ha = 4; c.hf = 2;
      c.vs = 1; c.vb = 1; c.va = 3; c.vf = 1;
      c.lat = (k == 0) ? 2 : (k == 1) ? 0 : (k == 2) ? 1 : 5;
    end
    c.hpol = (k == 1);
    c.vpol = (k == 1);
    return c;
  endfunction

  function automatic bit visible(cfg_t c, int h, int v);
    return (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha) &&
           (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
  endfunction

  // nn = clock edges counted since the last restart; position p = raster index.
  function automatic exp_t model(int k, int nn);
    cfg_t c = cfg_of(k);
    exp_t e;
    int   ht, vt, p, h, v;
    logic hr, vr;
    ht = c.hs + c.hb + c.ha + c.hf;
    vt = c.vs + c.vb + c.va + c.vf;
    e = '0;
    e.hs = !c.hpol;
    e.vs = !c.vpol;
    p = nn - 1;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      if (visible(c, h, v)) begin
        e.req = 1'b1;
        e.rx  = 11'(h - c.hs - c.hb);
        e.ry  = 11'(v - c.vs - c.vb);
      end
    end
    p = nn - 2 - c.lat;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      hr = (h < c.hs);
      vr = (v < c.vs);
      e.hs = c.hpol ? hr : !hr;
      e.vs = c.vpol ? vr : !vr;
      e.de = visible(c, h, v);
      e.fs = (h == 0) && (v == 0);
      e.ls = (h == 0);
      if (e.de) e.rgb = pix_of(11'(h - c.hs - c.hb), 11'(v - c.vs - c.vb));
    end
    return e;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic cmp(input string what, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d n=%0d got=%0h exp=%0h", what, k, n, act, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      e = model(k, n);
      cmp("req",         k, 32'(req_w[k]), 32'(e.req));
      cmp("req_x",       k, 32'(rx_w[k]),  32'(e.rx));
      cmp("req_y",       k, 32'(ry_w[k]),  32'(e.ry));
      cmp("hs",          k, 32'(hs_w[k]),  32'(e.hs));
      cmp("vs",          k, 32'(vs_w[k]),  32'(e.vs));
      cmp("de",          k, 32'(de_w[k]),  32'(e.de));
      cmp("frame_start", k, 32'(fs_w[k]),  32'(e.fs));
      cmp("line_start",  k, 32'(ls_w[k]),  32'(e.ls));
      cmp("rgb",         k, 32'(rgb_w[k]), 32'(e.rgb));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && en) n++;
    else n = 0;
    @(negedge clk);
    check_all();
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    int          ticks;
    logic        en;
    logic        hs, vs, de, fs, ls;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs [11];

  int          fs_cnt, ls_cnt, both_cnt, bad_cnt, guard, first, width, stray;
  int          hs_low, vs_low, ls_seen, ls2, first_de;
  logic [11:0] seen_mask;
  logic [23:0] first_rgb;
  bit          found;

  initial begin
    // instance 0: H 2/2/4/2, V 1/1/3/1, PIX_LAT=2, active-low syncs
    vecs[0]  = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    vecs[2]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[3]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[4]  = '{8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000};
    vecs[5]  = '{14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0000A5};
    vecs[6]  = '{13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0103A5};
    vecs[7]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[8]  = '{22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    vecs[9]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[10] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};

    vectors = 0;
    miscompares = 0;
    n = 0;
    rst_n = 1'b0;
    en = 1'b0;

    // reset state, including idle levels of the active-high instance
    @(negedge clk);
    check_all();
    cmp("pol_hs_idle", 1, 32'(hs_w[1]), 32'd0);
    cmp("pol_vs_idle", 1, 32'(vs_w[1]), 32'd0);
    repeat (2) tick();

    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en;
      repeat (vecs[i].ticks) tick();
      cmp("tbl.hs",  i, 32'(hs_w[0]),  32'(vecs[i].hs));
      cmp("tbl.vs",  i, 32'(vs_w[0]),  32'(vecs[i].vs));
      cmp("tbl.de",  i, 32'(de_w[0]),  32'(vecs[i].de));
      cmp("tbl.fs",  i, 32'(fs_w[0]),  32'(vecs[i].fs));
      cmp("tbl.ls",  i, 32'(ls_w[0]),  32'(vecs[i].ls));
      cmp("tbl.rgb", i, 32'(rgb_w[0]), 32'(vecs[i].rgb));
    end

    // three whole frames: pulse counts and request coverage
    en = 1'b0;
    tick();
    en = 1'b1;
    fs_cnt = 0; ls_cnt = 0; both_cnt = 0; bad_cnt = 0; seen_mask = '0;
    repeat (183) begin
      tick();
      if (fs_w[0]) fs_cnt++;
      if (ls_w[0]) ls_cnt++;
      if (fs_w[0] && ls_w[0]) both_cnt++;
      if (req_w[0]) begin
        if (int'(rx_w[0]) < 4 && int'(ry_w[0]) < 3) seen_mask[int'(ry_w[0]) * 4 + int'(rx_w[0])] = 1'b1;
        else bad_cnt++;
      end
    end
    cmp("fs_count",   0, 32'(fs_cnt),    32'd3);
    cmp("ls_count",   0, 32'(ls_cnt),    32'd18);
    cmp("fs_with_ls", 0, 32'(both_cnt),  32'd3);
    cmp("req_cover",  0, 32'(seen_mask), 32'hFFF);
    cmp("req_range",  0, 32'(bad_cnt),   32'd0);

    // en drop for 10 clocks in the vertical back porch
    guard = 0;
    while (((n % 60) / 10) != 1 && guard < 100) begin
      tick();
      guard++;
    end
    cmp("bp_reached", 0, 32'(guard < 100), 32'd1);
    en = 1'b0;
    repeat (10) begin
      tick();
      cmp("idle_de",  0, 32'(de_w[0]),  32'd0);
      cmp("idle_req", 3, 32'(req_w[3]), 32'd0);
    end
    en = 1'b1;
    first = -1; width = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (fs_w[0]) begin
        if (first < 0) first = n;
        width++;
      end
    end
    cmp("fs_after_en", 0, 32'(first), 32'd4);
    cmp("fs_width",    0, 32'(width), 32'd1);

    // async reset while de is high on instance 0
    guard = 0;
    while ((n % 60) != 28 && guard < 100) begin
      tick();
      guard++;
    end
    cmp("de_before_rst", 0, 32'(de_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    n = 0;
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    first = -1; stray = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (fs_w[0] && first < 0) first = n;
      if (de_w[0] && first < 0) stray++;
    end
    cmp("fs_after_rst", 0, 32'(first), 32'd4);
    cmp("stray_de",     0, 32'(stray), 32'd0);

    // default 640x480 instance up to its first visible pixel
    en = 1'b0;
    tick();
    en = 1'b1;
    found = 1'b0; hs_low = 0; vs_low = 0; ls_seen = 0; ls2 = -1; first_de = -1; first_rgb = '0;
    for (int t = 0; t < 30000 && !found; t++) begin
      tick();
      if (n >= 4 && n <= 803 && !hs_w[4]) hs_low++;
      if (n >= 4 && n <= 1603 && !vs_w[4]) vs_low++;
      if (ls_w[4]) begin
        ls_seen++;
        if (ls_seen == 2) ls2 = n;
      end
      if (de_w[4]) begin
        found = 1'b1;
        first_de = n;
        first_rgb = rgb_w[4];
      end
    end
    cmp("big_hs_low",    4, 32'(hs_low),    32'd96);
    cmp("big_vs_low",    4, 32'(vs_low),    32'd1600);
    cmp("big_line_len",  4, 32'(ls2),       32'd804);
    cmp("big_first_de",  4, 32'(first_de),  32'd28148);
    cmp("big_first_rgb", 4, 32'(first_rgb), 32'h0000A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator that replaces the fixed 640x480 timing block.
- Generic H/V timing, selectable sync polarity, soft enable.
- Pixel-request port with a configurable fetch latency. hs/vs/de/rgb leave perfectly aligned with returned pixel data.
- Sits between the frame-buffer/pattern source (pixel side) and the DAC/HDMI encoder (output side).

Parameters:
H_SYNC, 96, hsync width in clocks
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs
DATA_W, 24, pixel data width
PIX_LAT, 2, pixel source latency in clocks (0..15)
CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  soft enable; low = hold idle
req  out  1  pixel request (visible position)
req_x  out  CW  requested column, 0..H_ACTIVE-1
req_y  out  CW  requested row, 0..V_ACTIVE-1
pix_data  in  DATA_W  pixel for request issued PIX_LAT cycles earlier
hs  out  1  horizontal sync, polarity HS_POL
vs  out  1  vertical sync, polarity VS_POL
de  out  1  data enable (visible)
rgb  out  DATA_W  pixel output, zero when de=0
frame_start  out  1  one-cycle pulse, first output cycle of a frame
line_start  out  1  one-cycle pulse, first output cycle of each line

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise.
- Counter h_cnt runs 0..H_TOTAL-1 and wraps to 0. On that wrap, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0. Exactly H_TOTAL*V_TOTAL clocks per frame.
- Region order per line and per frame: sync, back, active, front.
- Stage-0 raw terms, decoded from the counters:
  - hs_raw = h_cnt < H_SYNC
  - vs_raw = v_cnt < V_SYNC
  - de_raw = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE)
  - fs_raw = (h_cnt==0 && v_cnt==0); ls_raw = (h_cnt==0)
- Stage 1 (registered):
  - req = de_raw.
  - req_x = h_cnt-(H_SYNC+H_BACK) and req_y = v_cnt-(V_SYNC+V_BACK) when de_raw; both 0 otherwise.
- Pixel source contract: pix_data is valid exactly PIX_LAT clocks after req. With PIX_LAT=0 the source is combinational from req_x/req_y.
- Output alignment:
  - hs_raw, vs_raw, de_raw, fs_raw, ls_raw pass through a PIX_LAT-deep shift register after stage 1, then one output register.
  - Outputs change PIX_LAT+1 cycles after the matching req; rgb registers pix_data in that same cycle.
  - hs = HS_POL ? hs_d : ~hs_d; vs likewise. rgb = de_d ? pix_data : 0.
- Reset (async, rst_n=0): counters = 0, delay line cleared.
  - req=0, req_x=0, req_y=0, de=0, rgb=0, frame_start=0, line_start=0.
  - hs = ~HS_POL, vs = ~VS_POL (inactive levels).
- en=0 (synchronous): on the next edge, counters and the delay line go to the reset state and all outputs go to their reset values. Held while en=0.
- en 0->1: counting starts at h_cnt=0, v_cnt=0.
  - First req (if any) follows normal timing.
  - First frame_start pulse appears PIX_LAT+1 cycles after the first counted cycle (stage-1 register plus PIX_LAT delay stages plus output register).
- Reset or en drop mid-frame: the frame is abandoned with no partial pulses. The restart is the same as the en 0->1 case.
- Simultaneous events: line_start and frame_start are both asserted on the first cycle of a frame.
- At h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, both counters wrap in the same edge.
- No arithmetic overflow is permitted. CW is checked by elaboration-time assertion; a failure is a configuration error.

Test Plan:
1. Default params, 2 full frames, PIX_LAT=2, source returns {req_y[7:0],req_x[7:0],8'hA5} delayed 2 -> expected response:
   - 800 clocks per line, 420000 per frame.
   - hs low for 96 clocks; vs low for 1600 clocks.
   - de high 640 clocks/line on 480 lines.
   - The first de cycle has rgb = 0x0000A5.
2. Latency sweep PIX_LAT = 0, 1, 5 with small timing (H 2/2/4/2, V 1/1/3/1) -> de rises exactly PIX_LAT+1 cycles after req, and rgb equals the data returned for that request on every cycle.
3. HS_POL=1, VS_POL=1 -> hs/vs idle low during reset and active high for H_SYNC clocks / V_SYNC lines.
4. Assert rst_n=0 mid-active-line, release after 3 clocks -> expected response:
   - All outputs take reset values within the reset window.
   - The next frame_start comes PIX_LAT+1 clocks after the first post-reset edge.
   - No stray de.
5. Drop en for 10 clocks in vertical back porch, then raise -> outputs idle during en=0, timing restarts from h=0, v=0, frame_start pulse width is exactly 1 clock.
6. Small timing, 3 frames -> expected response:
   - line_start count = 3*V_TOTAL; frame_start count = 3.
   - frame_start coincides with line_start.
   - req_x spans 0..H_ACTIVE-1 and req_y spans 0..V_ACTIVE-1 with no gaps.
